// File: rtl/frame_rcvr.sv
// -----------------------------------------------------------------------------
// frame_rcvr
//   Serial frame receiver. Hunts a bit stream for an HDR_W-bit header
//   (MSB first), then collects a DATA_W-bit payload (MSB first), optionally
//   followed by one even-parity bit, and pushes each accepted payload into a
//   small show-ahead output FIFO.
//
// Ports
//   clock      : single clock, all state updates on the rising edge
//   reset      : asynchronous, active-low reset
//   data_in    : serial input bit
//   valid_in   : data_in is sampled only when high
//   reading    : pop the FIFO head (ignored while the FIFO is empty)
//   clear_err  : clear the sticky error flags
//   ready      : FIFO holds at least one word
//   data_out   : FIFO head word (show-ahead)
//   fifo_count : number of words held
//   overrun    : sticky, a frame was dropped because the FIFO was full
//   parity_err : sticky, a frame was dropped on a parity mismatch
// -----------------------------------------------------------------------------
module frame_rcvr #(
    parameter int unsigned          DATA_W      = 32'd8,
    parameter int unsigned          HDR_W       = 32'd8,
    parameter logic [HDR_W-1:0]     HDR_PATTERN = 8'hA5,
    parameter int unsigned          FIFO_DEPTH  = 32'd4,
    parameter int unsigned          PARITY_EN   = 32'd0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            data_in,
    input  logic                            valid_in,
    input  logic                            reading,
    input  logic                            clear_err,
    output logic                            ready,
    output logic [DATA_W-1:0]               data_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overrun,
    output logic                            parity_err
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 32'd1;
    localparam int unsigned FILL_W = $clog2(HDR_W);
    localparam int unsigned BIT_W  = (DATA_W > 32'd1) ? $clog2(DATA_W) : 32'd1;

    // The fill counter saturates once enough bits are held to complete a header.
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HDR_W - 32'd1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 32'd1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        BODY   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Even parity holds when payload bits and the parity bit XOR to zero.
    function automatic logic even_parity_ok(input logic [DATA_W-1:0] word,
                                            input logic              pbit);
        return ~((^word) ^ pbit);
    endfunction

    // ---------------------------------------------------------------- state
    state_t                 state_q,   state_d;
    // Only HDR_W-1 history bits are kept; the live bit completes the window.
    logic [HDR_W-2:0]       hdr_q,     hdr_d;
    logic [FILL_W-1:0]      fill_q,    fill_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      pay_q,     pay_d;

    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]       count_q,   count_d;
    logic                   ready_q,   ready_d;
    logic [DATA_W-1:0]      data_out_q, data_out_d;
    logic                   overrun_q, overrun_d;
    logic                   perr_q,    perr_d;

    // ------------------------------------------------------------ internal
    logic [HDR_W-1:0]       hdr_shift_s;
    logic [DATA_W-1:0]      pay_shift_s;
    logic                   push_s;
    logic [DATA_W-1:0]      push_data_s;
    logic                   perr_set_s;
    logic                   full_s;
    logic                   pop_s;
    logic                   wr_en_s;
    logic                   ovr_set_s;

    // Frame FSM: header hunt, payload collection, parity check.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        pay_d       = pay_q;
        push_s      = 1'b0;
        push_data_s = pay_q;
        perr_set_s  = 1'b0;
        hdr_shift_s = {hdr_q, data_in};
        pay_shift_s = (pay_q << 1'b1) | DATA_W'(data_in);

        if (valid_in) begin
            case (state_q)
                HUNT: begin
                    // The history always shifts, so an overlapping header
                    // starting inside a failed candidate is still seen.
                    hdr_d = hdr_shift_s[HDR_W-2:0];
                    if ((fill_q >= FILL_MAX) && (hdr_shift_s == HDR_PATTERN)) begin
                        state_d   = BODY;
                        bit_cnt_d = {BIT_W{1'b0}};
                        fill_d    = {FILL_W{1'b0}};
                    end else if (fill_q < FILL_MAX) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else begin
                        fill_d = fill_q;
                    end
                end
                BODY: begin
                    pay_d = pay_shift_s;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = {BIT_W{1'b0}};
                        if (PARITY_EN != 32'd0) begin
                            state_d = PARITY;
                        end else begin
                            push_s      = 1'b1;
                            push_data_s = pay_shift_s;
                            state_d     = HUNT;
                            fill_d      = {FILL_W{1'b0}};
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                PARITY: begin
                    if (even_parity_ok(pay_q, data_in)) begin
                        push_s = 1'b1;
                    end else begin
                        perr_set_s = 1'b1;
                    end
                    state_d = HUNT;
                    fill_d  = {FILL_W{1'b0}};
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = {FILL_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output FIFO control, next head word and sticky error flags.
    always_comb begin
        full_s    = (count_q == CNT_FULL);
        pop_s     = reading && (count_q != {CNT_W{1'b0}});
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        wr_en_s   = push_s && (!full_s || pop_s);
        ovr_set_s = push_s && full_s && !pop_s;

        mem_d = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = push_data_s;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head is taken from the post-write memory so a word pushed into an
        // empty FIFO is visible on data_out right after its final bit.
        data_out_d = mem_d[rd_ptr_d];
        ready_d    = (count_d != {CNT_W{1'b0}});

        // Set wins over clear when both happen in one cycle.
        overrun_d = ovr_set_s  | (overrun_q & ~clear_err);
        perr_d    = perr_set_s | (perr_q    & ~clear_err);
    end

    // Receiver and FIFO state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            hdr_q      <= {(HDR_W-1){1'b0}};
            fill_q     <= {FILL_W{1'b0}};
            bit_cnt_q  <= {BIT_W{1'b0}};
            pay_q      <= {DATA_W{1'b0}};
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            ready_q    <= 1'b0;
            data_out_q <= {DATA_W{1'b0}};
            overrun_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            fill_q     <= fill_d;
            bit_cnt_q  <= bit_cnt_d;
            pay_q      <= pay_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            data_out_q <= data_out_d;
            overrun_q  <= overrun_d;
            perr_q     <= perr_d;
        end
    end

    assign ready      = ready_q;
    assign data_out   = data_out_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_frame_rcvr.sv
// -----------------------------------------------------------------------------
// tb_frame_rcvr
//   Directed self-checking bench for frame_rcvr. Two instances: u_dut with
//   default parameters and u_dut_p with PARITY_EN=1. Inputs are driven on
//   the falling edge and outputs are checked on a later falling edge.
// -----------------------------------------------------------------------------
module tb_frame_rcvr;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b0;

    logic       valid_a = 1'b0, reading_a = 1'b0, clear_a = 1'b0;
    logic       ready_a, ovr_a, perr_a;
    logic [7:0] dout_a;
    logic [2:0] cnt_a;

    logic       valid_p = 1'b0, reading_p = 1'b0, clear_p = 1'b0;
    logic       ready_p, ovr_p, perr_p;
    logic [7:0] dout_p;
    logic [2:0] cnt_p;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic       tgt_p = 1'b0;
    logic       gap_mode = 1'b0;

    frame_rcvr u_dut (
        .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_a),
        .reading(reading_a), .clear_err(clear_a), .ready(ready_a),
        .data_out(dout_a), .fifo_count(cnt_a), .overrun(ovr_a),
        .parity_err(perr_a)
    );

    frame_rcvr #(.PARITY_EN(32'd1)) u_dut_p (
        .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_p),
        .reading(reading_p), .clear_err(clear_p), .ready(ready_p),
        .data_out(dout_p), .fifo_count(cnt_p), .overrun(ovr_p),
        .parity_err(perr_p)
    );

    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One valid bit to the selected instance, with optional random idle gaps.
    task automatic drive_bit(input logic b);
        int g;
        if (gap_mode) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(negedge clock);
                valid_a = 1'b0;
                valid_p = 1'b0;
                data_in = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clock);
        data_in = b;
        valid_a = ~tgt_p;
        valid_p = tgt_p;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive_bit(v[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            valid_a = 1'b0; valid_p = 1'b0;
            reading_a = 1'b0; reading_p = 1'b0;
            clear_a = 1'b0; clear_p = 1'b0;
        end
    endtask

    task automatic pop_a();
        reading_a = 1'b1;
        @(negedge clock);
        reading_a = 1'b0;
    endtask

    logic [12:0] ovl_spec;
    logic [9:0]  ovl_late;
    logic [7:0]  exp_pops [4];

    initial begin
        // ---------------- reset state
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_ovr", 32'(ovr_a), 32'd0);
        check("rst_perr", 32'(perr_a), 32'd0);
        check("rst_dout", 32'(dout_a), 32'd0);
        reset = 1'b1;
        idle(2);

        // ---------------- defaults: A5 then 3C
        send_byte(8'hA5);
        send_byte(8'h3C);
        idle(1);
        check("def_ready", 32'(ready_a), 32'd1);
        check("def_dout", 32'(dout_a), 32'h3C);
        check("def_count", 32'(cnt_a), 32'd1);
        pop_a();
        check("def_ready_pop", 32'(ready_a), 32'd0);
        check("def_count_pop", 32'(cnt_a), 32'd0);

        // ---------------- overlap stream from the requirement list.
        // Header completes on bit 8; body is the remaining 0,0,1,0,1 plus
        // the first three 1s of FF -> 8'h2F. The last five 1s stay in HUNT.
        ovl_spec = 13'b1010010100101;
        for (int i = 12; i >= 0; i--) drive_bit(ovl_spec[i]);
        send_byte(8'hFF);
        idle(1);
        check("ovl_count", 32'(cnt_a), 32'd1);
        check("ovl_dout", 32'(dout_a), 32'h2F);
        pop_a();

        // Header overlapping a false candidate: 1,0,1,0 then A5 tail.
        ovl_late = 10'b1010100101;
        for (int i = 9; i >= 0; i--) drive_bit(ovl_late[i]);
        send_byte(8'hFF);
        idle(1);
        check("ovl2_count", 32'(cnt_a), 32'd1);
        check("ovl2_dout", 32'(dout_a), 32'hFF);
        pop_a();

        // ---------------- overrun: five frames, no reading
        for (int f = 1; f <= 5; f++) begin
            send_byte(8'hA5);
            send_byte(8'(f));
        end
        idle(1);
        check("ovr_count", 32'(cnt_a), 32'd4);
        check("ovr_flag", 32'(ovr_a), 32'd1);
        check("ovr_head", 32'(dout_a), 32'h01);
        clear_a = 1'b1;
        idle(1);
        check("ovr_clear", 32'(ovr_a), 32'd0);

        // Sixth frame lands while the head is popped: accepted, no overrun.
        send_byte(8'hA5);
        send_byte(8'h06);
        reading_a = 1'b1;
        idle(1);
        check("full_pp_count", 32'(cnt_a), 32'd4);
        check("full_pp_ovr", 32'(ovr_a), 32'd0);
        exp_pops[0] = 8'h02; exp_pops[1] = 8'h03;
        exp_pops[2] = 8'h04; exp_pops[3] = 8'h06;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pop%0d", k), 32'(dout_a), 32'(exp_pops[k]));
            pop_a();
        end
        check("empty_count", 32'(cnt_a), 32'd0);
        check("empty_ready", 32'(ready_a), 32'd0);
        pop_a();
        check("empty_pop_count", 32'(cnt_a), 32'd0);
        check("empty_pop_ovr", 32'(ovr_a), 32'd0);

        // ---------------- parity instance
        tgt_p = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h0F);
        drive_bit(1'b0);
        idle(1);
        check("par_ok_ready", 32'(ready_p), 32'd1);
        check("par_ok_dout", 32'(dout_p), 32'h0F);
        check("par_ok_count", 32'(cnt_p), 32'd1);
        check("par_ok_err", 32'(perr_p), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h0F);
        drive_bit(1'b1);
        idle(1);
        check("par_bad_err", 32'(perr_p), 32'd1);
        check("par_bad_count", 32'(cnt_p), 32'd1);
        clear_p = 1'b1;
        idle(1);
        check("par_clear", 32'(perr_p), 32'd0);
        // Clear in the same cycle as a new parity error: the set wins.
        send_byte(8'hA5);
        send_byte(8'h0F);
        drive_bit(1'b1);
        clear_p = 1'b1;
        idle(1);
        check("par_set_wins", 32'(perr_p), 32'd1);
        check("par_set_count", 32'(cnt_p), 32'd1);
        tgt_p = 1'b0;

        // ---------------- gaps in valid_in
        gap_mode = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h3C);
        gap_mode = 1'b0;
        idle(1);
        check("gap_count", 32'(cnt_a), 32'd1);
        check("gap_dout", 32'(dout_a), 32'h3C);
        pop_a();

        // ---------------- reset mid-frame
        send_byte(8'hA5);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        @(negedge clock);
        valid_a = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        idle(1);
        check("mid_rst_count", 32'(cnt_a), 32'd0);
        check("mid_rst_ready", 32'(ready_a), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h5A);
        idle(1);
        check("post_rst_count", 32'(cnt_a), 32'd1);
        check("post_rst_dout", 32'(dout_a), 32'h5A);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
